// File: rtl/hier_node_seq_if.sv
// Parent/child handshake bundle for one hierarchy node.
// The node sits on the slave side; whoever drives start and answers the lanes uses master.
interface hier_node_seq_if #(
    parameter int NUM_CHILD = 5,
    parameter int TMO_W     = 16
);
    logic                 start_i;
    logic [NUM_CHILD-1:0] child_en_i;
    logic [TMO_W-1:0]     tmo_cfg_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic                 tmo_o;
    logic [NUM_CHILD-1:0] child_start_o;
    logic [NUM_CHILD-1:0] child_done_i;
    logic [NUM_CHILD-1:0] child_err_i;
    logic [NUM_CHILD-1:0] done_vec_o;

    modport master (
        output start_i, child_en_i, tmo_cfg_i, child_done_i, child_err_i,
        input  busy_o, done_o, err_o, tmo_o, child_start_o, done_vec_o
    );

    modport slave (
        input  start_i, child_en_i, tmo_cfg_i, child_done_i, child_err_i,
        output busy_o, done_o, err_o, tmo_o, child_start_o, done_vec_o
    );
endinterface

// File: rtl/hier_node_seq.sv
// Hierarchy node: launches NUM_CHILD child lanes (parallel or in index order),
// collects their done/err pulses under a watchdog and reports one done pulse upward.
module hier_node_seq #(
    parameter int NUM_CHILD = 5,
    parameter int SEQ_MODE  = 0,
    parameter int TMO_W     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    hier_node_seq_if.slave bus
);
    localparam int LANE_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIN} state_t;

    state_t               state;
    logic [NUM_CHILD-1:0] mask;
    logic [NUM_CHILD-1:0] started;
    logic [LANE_W-1:0]    cur_lane;
    logic [TMO_W-1:0]     wd_cnt;

    logic [NUM_CHILD-1:0] accept_vec;
    logic [NUM_CHILD-1:0] remain;
    logic [NUM_CHILD-1:0] first_en;
    logic [NUM_CHILD-1:0] next_lane;
    logic [LANE_W-1:0]    first_idx;
    logic [LANE_W-1:0]    next_idx;
    logic                 wd_hit;

    function automatic logic [NUM_CHILD-1:0] lowest_bit(input logic [NUM_CHILD-1:0] v);
        return v & (~v + NUM_CHILD'(1));
    endfunction

    function automatic logic [LANE_W-1:0] lowest_idx(input logic [NUM_CHILD-1:0] v);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CHILD - 1; i >= 0; i--) begin
            if (v[i]) idx = LANE_W'(i);
        end
        return idx;
    endfunction

    // A done counts only in WAIT, so a done coincident with its own start pulse is dropped.
    assign accept_vec = (state == S_WAIT) ? (bus.child_done_i & mask & started) : '0;
    assign remain     = mask & ~bus.done_vec_o;
    assign first_en   = lowest_bit(bus.child_en_i);
    assign first_idx  = lowest_idx(bus.child_en_i);
    assign next_lane  = lowest_bit(remain);
    assign next_idx   = lowest_idx(remain);
    assign wd_hit     = (bus.tmo_cfg_i != '0) && (wd_cnt == bus.tmo_cfg_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            mask              <= '0;
            started           <= '0;
            cur_lane          <= '0;
            wd_cnt            <= '0;
            bus.busy_o        <= 1'b0;
            bus.done_o        <= 1'b0;
            bus.err_o         <= 1'b0;
            bus.tmo_o         <= 1'b0;
            bus.child_start_o <= '0;
            bus.done_vec_o    <= '0;
        end else begin
            bus.done_o        <= 1'b0;
            bus.child_start_o <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        mask           <= bus.child_en_i;
                        bus.done_vec_o <= '0;
                        bus.err_o      <= 1'b0;
                        bus.tmo_o      <= 1'b0;
                        bus.busy_o     <= 1'b1;
                        wd_cnt         <= '0;
                        state          <= S_LAUNCH;
                        if (SEQ_MODE != 0) begin
                            bus.child_start_o <= first_en;
                            started           <= first_en;
                            cur_lane          <= first_idx;
                        end else begin
                            bus.child_start_o <= bus.child_en_i;
                            started           <= bus.child_en_i;
                            cur_lane          <= '0;
                        end
                    end
                end

                S_LAUNCH: begin
                    wd_cnt <= wd_cnt + TMO_W'(1);
                    if (mask == '0) begin
                        bus.done_o <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        state <= S_WAIT;
                    end
                end

                // Completion is judged on the registered done vector; the watchdog takes priority.
                S_WAIT: begin
                    bus.done_vec_o <= bus.done_vec_o | accept_vec;
                    if ((accept_vec & bus.child_err_i) != '0) bus.err_o <= 1'b1;
                    if (wd_hit) begin
                        bus.tmo_o  <= 1'b1;
                        bus.err_o  <= 1'b1;
                        bus.done_o <= 1'b1;
                        state      <= S_FIN;
                    end else begin
                        wd_cnt <= wd_cnt + TMO_W'(1);
                        if (SEQ_MODE != 0) begin
                            if (bus.done_vec_o[cur_lane]) begin
                                if (remain != '0) begin
                                    bus.child_start_o <= next_lane;
                                    started           <= started | next_lane;
                                    cur_lane          <= next_idx;
                                    wd_cnt            <= '0;
                                    state             <= S_LAUNCH;
                                end else begin
                                    bus.done_o <= 1'b1;
                                    state      <= S_FIN;
                                end
                            end
                        end else if (bus.done_vec_o == mask) begin
                            bus.done_o <= 1'b1;
                            state      <= S_FIN;
                        end
                    end
                end

                S_FIN: begin
                    bus.busy_o <= 1'b0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
